// File: rtl/instruction_decode_unit_pkg.sv
// Shared MIPS decode constants: opcodes, R-type function codes, ALU operations and the
// control-signal bundle passed from the decoder to the ID/EX boundary.
package instruction_decode_unit_pkg;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnSll = 6'h00;
    localparam logic [5:0] FnSrl = 6'h02;
    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    localparam logic [4:0] RegRa = 5'd31;

    typedef enum logic [2:0] {
        AluAdd = 3'd0,
        AluSub = 3'd1,
        AluAnd = 3'd2,
        AluOr  = 3'd3,
        AluSlt = 3'd4,
        AluSll = 3'd5,
        AluSrl = 3'd6,
        AluLui = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic reg_dst;
        logic branch;
        logic branch_ne;
        logic jump;
        logic jump_reg;
        logic link;
    } ctrl_t;

    // Strip every control that would change architectural state, leaving datapath selects.
    function automatic ctrl_t bubble(input ctrl_t c);
        ctrl_t r;
        r           = c;
        r.reg_write = 1'b0;
        r.mem_read  = 1'b0;
        r.mem_write = 1'b0;
        r.branch    = 1'b0;
        r.branch_ne = 1'b0;
        r.jump      = 1'b0;
        r.jump_reg  = 1'b0;
        r.link      = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/instruction_decode_unit_decoder.sv
// Purely combinational MIPS instruction decoder: field split, immediate extension,
// jump target formation and control generation for the supported instruction subset.
module instruction_decode_unit_decoder
    import instruction_decode_unit_pkg::*;
(
    input  logic [31:0] i_instr,
    input  logic [29:0] i_pc_word,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rd,
    output logic [4:0]  o_shamt,
    output logic [5:0]  o_funct,
    output logic [31:0] o_immediate,
    output logic [31:0] o_jump_target,
    output ctrl_t       o_ctrl,
    output alu_op_e     o_alu_op,
    output logic        o_uses_rt,
    output logic        o_illegal
);

    logic [5:0] w_opcode;
    logic [3:0] w_pc4_upper;
    logic       w_zero_ext;

    assign w_opcode = i_instr[31:26];
    assign o_rs     = i_instr[25:21];
    assign o_rt     = i_instr[20:16];
    assign o_rd     = (w_opcode == OpJal) ? RegRa : i_instr[15:11];
    assign o_shamt  = i_instr[10:6];
    assign o_funct  = i_instr[5:0];

    assign w_zero_ext  = (w_opcode == OpAndi) || (w_opcode == OpOri);
    assign o_immediate = w_zero_ext ? {16'h0000, i_instr[15:0]}
                                    : {{16{i_instr[15]}}, i_instr[15:0]};

    // Only the top nibble of pc+4 is kept; it increments when the low word bits are all ones.
    assign w_pc4_upper   = i_pc_word[29:26] + {3'b000, &i_pc_word[25:0]};
    assign o_jump_target = {w_pc4_upper, i_instr[25:0], 2'b00};

    assign o_uses_rt = (w_opcode == OpRtype) || (w_opcode == OpBeq) ||
                       (w_opcode == OpBne) || (w_opcode == OpSw);

    always_comb begin
        o_ctrl    = '0;
        o_alu_op  = AluAdd;
        o_illegal = 1'b0;
        case (w_opcode)
            OpRtype: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
                case (o_funct)
                    FnAdd: o_alu_op = AluAdd;
                    FnSub: o_alu_op = AluSub;
                    FnAnd: o_alu_op = AluAnd;
                    FnOr:  o_alu_op = AluOr;
                    FnSlt: o_alu_op = AluSlt;
                    FnSll: o_alu_op = AluSll;
                    FnSrl: o_alu_op = AluSrl;
                    FnJr: begin
                        o_ctrl.reg_write = 1'b0;
                        o_ctrl.reg_dst   = 1'b0;
                        o_ctrl.jump_reg  = 1'b1;
                    end
                    default: begin
                        o_ctrl    = '0;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            OpLw: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.alu_src    = 1'b1;
            end
            OpSw: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
            end
            OpBeq: begin
                o_ctrl.branch = 1'b1;
                o_alu_op      = AluSub;
            end
            OpBne: begin
                o_ctrl.branch_ne = 1'b1;
                o_alu_op         = AluSub;
            end
            OpAddi, OpSlti, OpAndi, OpOri, OpLui: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                case (w_opcode)
                    OpSlti:  o_alu_op = AluSlt;
                    OpAndi:  o_alu_op = AluAnd;
                    OpOri:   o_alu_op = AluOr;
                    OpLui:   o_alu_op = AluLui;
                    default: o_alu_op = AluAdd;
                endcase
            end
            OpJ: o_ctrl.jump = 1'b1;
            OpJal: begin
                o_ctrl.jump      = 1'b1;
                o_ctrl.link      = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instruction_decode_unit.sv
// IF/ID pipeline latch with decode, load-use hazard detection (stall + bubble) and flush.
// Decode is combinational from the latch, so a captured instruction is visible one edge later.
module instruction_decode_unit
    import instruction_decode_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      system_clock,
    input  logic                      reset,
    input  logic                      if_valid,
    input  logic [DATA_WIDTH-1:0]     if_instruction,
    input  logic [DATA_WIDTH-1:0]     if_program_counter,
    input  logic                      flush,
    input  logic                      ex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rt,
    output logic                      id_stall,
    output logic                      id_valid,
    output logic [DATA_WIDTH-1:0]     id_program_counter,
    output logic [REG_ADDR_WIDTH-1:0] id_rs,
    output logic [REG_ADDR_WIDTH-1:0] id_rt,
    output logic [REG_ADDR_WIDTH-1:0] id_rd,
    output logic [REG_ADDR_WIDTH-1:0] id_shamt,
    output logic [5:0]                id_funct,
    output logic [DATA_WIDTH-1:0]     id_immediate,
    output logic [DATA_WIDTH-1:0]     id_jump_target,
    output logic                      id_reg_write,
    output logic                      id_mem_read,
    output logic                      id_mem_write,
    output logic                      id_mem_to_reg,
    output logic                      id_alu_src,
    output logic                      id_reg_dst,
    output logic                      id_branch,
    output logic                      id_branch_ne,
    output logic                      id_jump,
    output logic                      id_jump_reg,
    output logic                      id_link,
    output logic [2:0]                id_alu_op,
    output logic                      id_illegal
);

    logic [DATA_WIDTH-1:0] r_instr;
    logic [DATA_WIDTH-1:0] r_pc;
    logic                  r_valid;

    ctrl_t   w_dec_ctrl;
    ctrl_t   w_ctrl;
    alu_op_e w_dec_alu_op;
    alu_op_e w_alu_op;
    logic    w_uses_rt;
    logic    w_dec_illegal;
    logic    w_hazard;

    instruction_decode_unit_decoder u_decoder (
        .i_instr       (r_instr),
        .i_pc_word     (r_pc[31:2]),
        .o_rs          (id_rs),
        .o_rt          (id_rt),
        .o_rd          (id_rd),
        .o_shamt       (id_shamt),
        .o_funct       (id_funct),
        .o_immediate   (id_immediate),
        .o_jump_target (id_jump_target),
        .o_ctrl        (w_dec_ctrl),
        .o_alu_op      (w_dec_alu_op),
        .o_uses_rt     (w_uses_rt),
        .o_illegal     (w_dec_illegal)
    );

    // Register 0 is never a real load destination, so it cannot create a dependency.
    assign w_hazard = r_valid && ex_mem_read && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (w_uses_rt && (ex_rt == id_rt)));

    assign id_stall           = w_hazard && !flush;
    assign id_valid           = r_valid && !w_hazard;
    assign id_program_counter = r_pc;
    assign id_illegal         = r_valid && w_dec_illegal;

    always_ff @(posedge system_clock) begin
        if (!reset) begin
            r_instr <= '0;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (!id_stall) begin
            r_instr <= if_instruction;
            r_pc    <= if_program_counter;
            r_valid <= if_valid;
        end
    end

    always_comb begin
        w_ctrl   = w_dec_ctrl;
        w_alu_op = w_dec_alu_op;
        if (!r_valid) begin
            w_ctrl   = '0;
            w_alu_op = AluAdd;
        end else if (w_hazard) begin
            w_ctrl = bubble(w_dec_ctrl);
        end
    end

    assign id_reg_write  = w_ctrl.reg_write;
    assign id_mem_read   = w_ctrl.mem_read;
    assign id_mem_write  = w_ctrl.mem_write;
    assign id_mem_to_reg = w_ctrl.mem_to_reg;
    assign id_alu_src    = w_ctrl.alu_src;
    assign id_reg_dst    = w_ctrl.reg_dst;
    assign id_branch     = w_ctrl.branch;
    assign id_branch_ne  = w_ctrl.branch_ne;
    assign id_jump       = w_ctrl.jump;
    assign id_jump_reg   = w_ctrl.jump_reg;
    assign id_link       = w_ctrl.link;
    assign id_alu_op     = w_alu_op;

endmodule

// File: tb/tb_instruction_decode_unit.sv
// Scoreboard bench for instruction_decode_unit: expectations are queued as stimulus is
// driven and compared against the ID outputs once the latch presents them.
module tb_instruction_decode_unit;

    logic        system_clock;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_program_counter;
    logic        flush;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_program_counter;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [5:0]  id_funct;
    logic [31:0] id_immediate;
    logic [31:0] id_jump_target;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_mem_to_reg;
    logic        id_alu_src;
    logic        id_reg_dst;
    logic        id_branch;
    logic        id_branch_ne;
    logic        id_jump;
    logic        id_jump_reg;
    logic        id_link;
    logic [2:0]  id_alu_op;
    logic        id_illegal;

    instruction_decode_unit #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .system_clock       (system_clock),
        .reset              (reset),
        .if_valid           (if_valid),
        .if_instruction     (if_instruction),
        .if_program_counter (if_program_counter),
        .flush              (flush),
        .ex_mem_read        (ex_mem_read),
        .ex_rt              (ex_rt),
        .id_stall           (id_stall),
        .id_valid           (id_valid),
        .id_program_counter (id_program_counter),
        .id_rs              (id_rs),
        .id_rt              (id_rt),
        .id_rd              (id_rd),
        .id_shamt           (id_shamt),
        .id_funct           (id_funct),
        .id_immediate       (id_immediate),
        .id_jump_target     (id_jump_target),
        .id_reg_write       (id_reg_write),
        .id_mem_read        (id_mem_read),
        .id_mem_write       (id_mem_write),
        .id_mem_to_reg      (id_mem_to_reg),
        .id_alu_src         (id_alu_src),
        .id_reg_dst         (id_reg_dst),
        .id_branch          (id_branch),
        .id_branch_ne       (id_branch_ne),
        .id_jump            (id_jump),
        .id_jump_reg        (id_jump_reg),
        .id_link            (id_link),
        .id_alu_op          (id_alu_op),
        .id_illegal         (id_illegal)
    );

    // Control order: reg_write mem_read mem_write mem_to_reg alu_src reg_dst
    //                branch branch_ne jump jump_reg link
    localparam logic [10:0] CNone = 11'h000;
    localparam logic [10:0] CImm  = 11'h440;
    localparam logic [10:0] CReg  = 11'h420;
    localparam logic [10:0] CLw   = 11'h6C0;
    localparam logic [10:0] CSw   = 11'h140;
    localparam logic [10:0] CBeq  = 11'h010;
    localparam logic [10:0] CBne  = 11'h008;
    localparam logic [10:0] CJ    = 11'h004;
    localparam logic [10:0] CJal  = 11'h425;
    localparam logic [10:0] CJr   = 11'h002;

    typedef struct {
        logic        valid;
        logic        stall;
        logic        illegal;
        logic [10:0] ctrl;
        logic [2:0]  alu;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] jt;
        logic [31:0] pc;
        bit          chk_jt;
    } exp_t;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_errors = 0;
    string cur = "";

    initial system_clock = 1'b0;
    always #5 system_clock = ~system_clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s/%s got 0x%0h exp 0x%0h", cur, tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic st, input logic il,
                                input logic [10:0] c, input logic [2:0] op,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [31:0] imm,
                                input logic [31:0] jt, input logic [31:0] pc,
                                input bit cj);
        exp_t e;
        e.valid = v;   e.stall = st; e.illegal = il; e.ctrl = c; e.alu = op;
        e.rs = rs;     e.rt = rt;    e.rd = rd;      e.imm = imm; e.jt = jt;
        e.pc = pc;     e.chk_jt = cj;
        return e;
    endfunction

    task automatic check_out();
        exp_t        e;
        logic [10:0] got_ctrl;
        check_eq("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        got_ctrl = {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src,
                    id_reg_dst, id_branch, id_branch_ne, id_jump, id_jump_reg, id_link};
        check_eq("valid", 32'(id_valid), 32'(e.valid));
        check_eq("stall", 32'(id_stall), 32'(e.stall));
        check_eq("illegal", 32'(id_illegal), 32'(e.illegal));
        check_eq("ctrl", 32'(got_ctrl), 32'(e.ctrl));
        check_eq("alu_op", 32'(id_alu_op), 32'(e.alu));
        check_eq("rs", 32'(id_rs), 32'(e.rs));
        check_eq("rt", 32'(id_rt), 32'(e.rt));
        check_eq("rd", 32'(id_rd), 32'(e.rd));
        check_eq("imm", id_immediate, e.imm);
        check_eq("pc", id_program_counter, e.pc);
        if (e.chk_jt) check_eq("jump_target", id_jump_target, e.jt);
    endtask

    task automatic tick();
        @(posedge system_clock);
        #1;
    endtask

    task automatic probe(input exp_t e);
        sb.push_back(e);
        #1;
        check_out();
    endtask

    task automatic run_vec(input string name, input logic [31:0] instr, input logic [31:0] pc,
                           input logic il, input logic [10:0] c, input logic [2:0] op,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] imm, input logic [31:0] jt, input bit cj);
        cur                = name;
        if_valid           = 1'b1;
        if_instruction     = instr;
        if_program_counter = pc;
        sb.push_back(mk(1'b1, 1'b0, il, c, op, rs, rt, rd, imm, jt, pc, cj));
        tick();
        if_valid = 1'b0;
        #1;
        check_out();
    endtask

    initial begin
        reset              = 1'b0;
        if_valid           = 1'b0;
        if_instruction     = 32'h0;
        if_program_counter = 32'h0;
        flush              = 1'b0;
        ex_mem_read        = 1'b0;
        ex_rt              = 5'd0;
        repeat (3) tick();
        cur = "reset";
        probe(mk(0, 0, 0, CNone, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1));
        reset = 1'b1;

        // name           instr         pc            il ctrl  alu  rs  rt  rd  imm           jt
        run_vec("addi",   32'h20080005, 32'h00000000, 0, CImm, 3'd0, 0, 8, 0, 32'h00000005,
                32'h00200014, 1);
        run_vec("addi_n", 32'h2008FFFF, 32'h00000004, 0, CImm, 3'd0, 0, 8, 31, 32'hFFFFFFFF,
                32'h0, 0);
        run_vec("andi",   32'h3108FFFF, 32'h00000008, 0, CImm, 3'd2, 8, 8, 31, 32'h0000FFFF,
                32'h0423FFFC, 1);
        run_vec("j",      32'h08000010, 32'h00000100, 0, CJ, 3'd0, 0, 0, 0, 32'h00000010,
                32'h00000040, 1);
        run_vec("jal_hi", 32'h0C000001, 32'hEFFFFFFC, 0, CJal, 3'd0, 0, 0, 31, 32'h00000001,
                32'hF0000004, 1);
        run_vec("jal_wr", 32'h0C000001, 32'hFFFFFFFC, 0, CJal, 3'd0, 0, 0, 31, 32'h00000001,
                32'h00000004, 1);
        run_vec("lw",     32'h8D280004, 32'h00000010, 0, CLw, 3'd0, 9, 8, 0, 32'h00000004,
                32'h0, 0);
        run_vec("sw",     32'hAD280004, 32'h00000014, 0, CSw, 3'd0, 9, 8, 0, 32'h00000004,
                32'h0, 0);
        run_vec("beq",    32'h1128FFFE, 32'h00000018, 0, CBeq, 3'd1, 9, 8, 31, 32'hFFFFFFFE,
                32'h0, 0);
        run_vec("bne",    32'h1528FFFE, 32'h0000001C, 0, CBne, 3'd1, 9, 8, 31, 32'hFFFFFFFE,
                32'h0, 0);
        run_vec("add",    32'h01295020, 32'h00000020, 0, CReg, 3'd0, 9, 9, 10, 32'h00005020,
                32'h0, 0);
        run_vec("sub",    32'h01295022, 32'h00000024, 0, CReg, 3'd1, 9, 9, 10, 32'h00005022,
                32'h0, 0);
        run_vec("and",    32'h01295024, 32'h00000028, 0, CReg, 3'd2, 9, 9, 10, 32'h00005024,
                32'h0, 0);
        run_vec("or",     32'h01295025, 32'h0000002C, 0, CReg, 3'd3, 9, 9, 10, 32'h00005025,
                32'h0, 0);
        run_vec("slt",    32'h0129502A, 32'h00000030, 0, CReg, 3'd4, 9, 9, 10, 32'h0000502A,
                32'h0, 0);
        run_vec("sll",    32'h00094080, 32'h00000034, 0, CReg, 3'd5, 0, 9, 8, 32'h00004080,
                32'h0, 0);
        run_vec("srl",    32'h00094082, 32'h00000038, 0, CReg, 3'd6, 0, 9, 8, 32'h00004082,
                32'h0, 0);
        run_vec("jr",     32'h03E00008, 32'h0000003C, 0, CJr, 3'd0, 31, 0, 0, 32'h00000008,
                32'h0, 0);
        run_vec("slti",   32'h2928FFFF, 32'h00000040, 0, CImm, 3'd4, 9, 8, 31, 32'hFFFFFFFF,
                32'h0, 0);
        run_vec("ori",    32'h3528FFFF, 32'h00000044, 0, CImm, 3'd3, 9, 8, 31, 32'h0000FFFF,
                32'h0, 0);
        run_vec("lui",    32'h3C081234, 32'h00000048, 0, CImm, 3'd7, 0, 8, 2, 32'h00001234,
                32'h0, 0);
        run_vec("ill_op", 32'hFC000000, 32'h0000004C, 1, CNone, 3'd0, 0, 0, 0, 32'h0,
                32'h0, 0);
        run_vec("ill_fn", 32'h0129503F, 32'h00000050, 1, CNone, 3'd0, 9, 9, 10, 32'h0000503F,
                32'h0, 0);

        // Load-use on rs: stall two cycles with latch held, then release.
        run_vec("add_h",  32'h01295020, 32'h00000200, 0, CReg, 3'd0, 9, 9, 10, 32'h00005020,
                32'h0, 0);
        cur                = "haz_rs";
        ex_mem_read        = 1'b1;
        ex_rt              = 5'd9;
        if_valid           = 1'b1;
        if_instruction     = 32'h20080005;
        if_program_counter = 32'h00000204;
        probe(mk(0, 1, 0, 11'h020, 3'd0, 9, 9, 10, 32'h00005020, 32'h0, 32'h200, 0));
        tick();
        cur = "haz_hold";
        probe(mk(0, 1, 0, 11'h020, 3'd0, 9, 9, 10, 32'h00005020, 32'h0, 32'h200, 0));
        cur         = "haz_clr";
        ex_mem_read = 1'b0;
        probe(mk(1, 0, 0, CReg, 3'd0, 9, 9, 10, 32'h00005020, 32'h0, 32'h200, 0));
        tick();
        if_valid = 1'b0;
        cur      = "after_stall";
        probe(mk(1, 0, 0, CImm, 3'd0, 0, 8, 0, 32'h00000005, 32'h0, 32'h204, 0));

        // addi holds rs=0, rt=8: ex_rt=0 and an rt-only match must not stall.
        cur         = "ex_rt0";
        ex_mem_read = 1'b1;
        ex_rt       = 5'd0;
        probe(mk(1, 0, 0, CImm, 3'd0, 0, 8, 0, 32'h00000005, 32'h0, 32'h204, 0));
        cur   = "rt_unused";
        ex_rt = 5'd8;
        probe(mk(1, 0, 0, CImm, 3'd0, 0, 8, 0, 32'h00000005, 32'h0, 32'h204, 0));
        ex_mem_read = 1'b0;

        // sw reads rt, so a match on rt alone stalls.
        run_vec("sw_h",   32'hAD280004, 32'h00000300, 0, CSw, 3'd0, 9, 8, 0, 32'h00000004,
                32'h0, 0);
        cur         = "haz_rt";
        ex_mem_read = 1'b1;
        ex_rt       = 5'd8;
        probe(mk(0, 1, 0, 11'h040, 3'd0, 9, 8, 0, 32'h00000004, 32'h0, 32'h300, 0));

        // Flush beats hazard and discards the incoming instruction.
        cur                = "flush_haz";
        flush              = 1'b1;
        if_valid           = 1'b1;
        if_instruction     = 32'h20080005;
        if_program_counter = 32'h00000304;
        probe(mk(0, 0, 0, 11'h040, 3'd0, 9, 8, 0, 32'h00000004, 32'h0, 32'h300, 0));
        tick();
        flush       = 1'b0;
        ex_mem_read = 1'b0;
        if_valid    = 1'b0;
        cur         = "post_flush";
        probe(mk(0, 0, 0, CNone, 3'd0, 9, 8, 0, 32'h00000004, 32'h0, 32'h300, 0));

        // Reset during a stall clears the latch and drops the stall.
        run_vec("add_r",  32'h01295020, 32'h00000400, 0, CReg, 3'd0, 9, 9, 10, 32'h00005020,
                32'h0, 0);
        cur         = "stall_pre_rst";
        ex_mem_read = 1'b1;
        ex_rt       = 5'd9;
        probe(mk(0, 1, 0, 11'h020, 3'd0, 9, 9, 10, 32'h00005020, 32'h0, 32'h400, 0));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        cur   = "rst_mid_stall";
        probe(mk(0, 0, 0, CNone, 3'd0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1));
        ex_mem_read = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
